// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage of the 8-bit processor. Holds the fetch address,
// issues one read at a time to instruction memory and queues the returned
// words in a small FIFO for decode. A redirect flushes the FIFO and any
// response that is still in flight is thrown away when it arrives.
//
// Ports
//   clk, rst        : clock; asynchronous active-high reset
//   pc_out          : current fetch address, to the program counter
//   pc_inc          : pc_out + 1 (mod 256), from the program counter
//   redirect        : branch/jump taken, with target redirect_addr
//   imem_req/addr   : read request and address (address always equals pc_out)
//   imem_ready      : memory accepts the request this cycle
//   imem_rvalid/rdata : read response
//   instr_valid/data/addr : FIFO head towards decode
//   instr_ready     : decode consumes the head this cycle
// -----------------------------------------------------------------------------
module instr_fetch #(
   parameter int unsigned INSTR_W    = 16,
   parameter logic [7:0]  RESET_ADDR = 8'h00,
   parameter int unsigned DEPTH      = 2
) (
   input  logic               clk,
   input  logic               rst,
   output logic [7:0]         pc_out,
   input  logic [7:0]         pc_inc,
   input  logic               redirect,
   input  logic [7:0]         redirect_addr,
   output logic               imem_req,
   output logic [7:0]         imem_addr,
   input  logic               imem_ready,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr_data,
   output logic [7:0]         instr_addr,
   input  logic               instr_ready
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_DROP  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         fa_q, fa_d;
   logic [7:0]         req_addr_q, req_addr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [7:0]         ent_addr_q [DEPTH];
   logic [7:0]         ent_addr_d [DEPTH];
   logic [INSTR_W-1:0] ent_data_q [DEPTH];
   logic [INSTR_W-1:0] ent_data_d [DEPTH];
   logic [DEPTH-1:0]   ent_we;

   logic accept;
   logic push;
   logic pop;

   // Request only when the FIFO can absorb the response; this is what makes
   // an overflow path unnecessary. rst is folded in so no request is shown
   // while reset is held.
   assign imem_req  = (state_q == S_FETCH) && (count_q < DEPTH_C) && !redirect && !rst;
   assign imem_addr = fa_q;
   assign pc_out    = fa_q;

   assign accept = imem_req && imem_ready;
   // Responses land only in WAIT; in DROP, in FETCH (stray) or under a
   // redirect they are discarded.
   assign push   = (state_q == S_WAIT) && imem_rvalid && !redirect;
   // A redirect clears the buffer, so a same-cycle pop has no effect.
   assign pop    = instr_valid && instr_ready && !redirect;

   // Decode sees only registered FIFO state.
   assign instr_valid = (count_q != '0);
   assign instr_data  = ent_data_q[rd_ptr_q];
   assign instr_addr  = ent_addr_q[rd_ptr_q];

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
      assign ent_we[gi] = push && (wr_ptr_q == PTR_W'(gi));
   end

   always_comb begin
      state_d    = state_q;
      fa_d       = fa_q;
      req_addr_d = req_addr_q;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      ent_addr_d = ent_addr_q;
      ent_data_d = ent_data_q;

      for (int i = 0; i < DEPTH; i++) begin
         if (ent_we[i]) begin
            ent_addr_d[i] = req_addr_q;
            ent_data_d[i] = imem_rdata;
         end
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // The address of the accepted request travels with its data.
      if (accept) begin
         fa_d       = pc_inc;
         req_addr_d = fa_q;
      end

      case (state_q)
         S_FETCH: begin
            if (accept) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               state_d = S_FETCH;
            end else if (redirect) begin
               // Response still owed by memory; remember to discard it.
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            if (imem_rvalid) begin
               state_d = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase

      // Redirect overrides every other update of the address and the FIFO.
      if (redirect) begin
         fa_d     = redirect_addr;
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_FETCH;
         fa_q       <= RESET_ADDR;
         req_addr_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_addr_q[i] <= '0;
            ent_data_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         fa_q       <= fa_d;
         req_addr_q <= req_addr_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ent_addr_q <= ent_addr_d;
         ent_data_q <= ent_data_d;
      end
   end

endmodule
